// File: rtl/a2d_spi_resp_pkg.sv
// ============================================================================
// Module : a2d_pkg
// Brief  : Shared constants, state type and LFSR helper for the A2D SPI responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package a2d_pkg;

    localparam int CMD_CH_MSB = 13;
    localparam int CMD_CH_LSB = 11;
    localparam int FRM_BITS   = 16;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } resp_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/a2d_spi_resp_edge_sync.sv
// ============================================================================
// Module : spi_edge_sync
// Brief  : Two-flop synchronizer plus history flop giving rise/fall strobes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_edge_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= {3{RST_VAL}};
        end else begin
            sync_ff <= {sync_ff[1:0], async_in};
        end
    end

    // Edges come from the settled second stage against the history flop
    assign rise = sync_ff[1] & ~sync_ff[2];
    assign fall = ~sync_ff[1] & sync_ff[2];

endmodule

`default_nettype wire

// File: rtl/a2d_spi_resp.sv
// ============================================================================
// Module : a2d_spi_resp
// Brief  : SPI responder emulating an 8-channel 12-bit ADC; each 16-bit frame
//          returns the channel addressed by the previous frame.
//          Optional build macro A2D_RESP_NOISE_EN adds LFSR dither to bits [1:0].
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module a2d_spi_resp
    import a2d_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DW     = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 SCLK,
    input  logic                 MOSI,
    output logic                 MISO,
    input  logic [NUM_CH*DW-1:0] ch_data,
    output logic [2:0]           chnl,
    output logic                 frm_done,
    output logic                 frm_err
);

    localparam int          PAD     = FRM_BITS - DW;
    localparam logic [4:0]  CNT_SAT = 5'd17;
    localparam logic [4:0]  CNT_END = 5'(FRM_BITS);

    resp_state_t         state;
    logic [FRM_BITS-1:0] rx_shft;
    logic [FRM_BITS-1:0] tx_shft;
    logic [4:0]          bit_cnt;
    logic                fst_rise;
    logic [1:0]          mosi_ff;

    logic                ss_rise;
    logic                ss_fall;
    logic                sclk_rise;
    logic                sclk_fall;
    logic [FRM_BITS-1:0] rx_nxt;
    logic [FRM_BITS-1:0] rx_eff;
    logic [4:0]          cnt_nxt;
    logic [4:0]          cnt_eff;
    logic [DW-1:0]       noise;
    logic [DW-1:0]       snap;
    logic                frame_ok;
    logic                unused_rx;

    spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (SS_n),
        .rise     (ss_rise),
        .fall     (ss_fall)
    );

    spi_edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (SCLK),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_ff <= 2'b00;
        end else begin
            mosi_ff <= {mosi_ff[0], MOSI};
        end
    end

    // A coincident SCLK rise is folded in before the frame-end check
    assign rx_nxt   = {rx_shft[FRM_BITS-2:0], mosi_ff[1]};
    assign cnt_nxt  = (bit_cnt == CNT_SAT) ? CNT_SAT : bit_cnt + 5'd1;
    assign rx_eff   = sclk_rise ? rx_nxt  : rx_shft;
    assign cnt_eff  = sclk_rise ? cnt_nxt : bit_cnt;
    assign frame_ok = (state == ACTIVE) && ss_rise && (cnt_eff == CNT_END);

    assign unused_rx = ^{rx_eff[FRM_BITS-1:CMD_CH_MSB+1], rx_eff[CMD_CH_LSB-1:0]};

`ifdef A2D_RESP_NOISE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (frame_ok) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign noise = {{(DW-2){1'b0}}, lfsr[1:0]};
`else
    assign noise = '0;
`endif

    // Out-of-range channel indices fall through to zero
    always_comb begin
        snap = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (int'(chnl) == n) begin
                snap = ch_data[n*DW +: DW] ^ noise;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rx_shft  <= '0;
            tx_shft  <= '1;
            bit_cnt  <= '0;
            fst_rise <= 1'b0;
            chnl     <= 3'd0;
            frm_done <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            frm_done <= 1'b0;
            frm_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        tx_shft  <= {{PAD{1'b0}}, snap};
                        bit_cnt  <= '0;
                        fst_rise <= 1'b0;
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (sclk_rise) begin
                        rx_shft  <= rx_nxt;
                        bit_cnt  <= cnt_nxt;
                        fst_rise <= 1'b1;
                    end else if (sclk_fall && fst_rise) begin
                        tx_shft <= {tx_shft[FRM_BITS-2:0], 1'b1};
                    end
                    if (ss_rise) begin
                        if (cnt_eff == CNT_END) begin
                            chnl     <= rx_eff[CMD_CH_MSB:CMD_CH_LSB];
                            frm_done <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign MISO = (state == ACTIVE) ? tx_shft[FRM_BITS-1] : 1'b1;

endmodule

`default_nettype wire
